// File: rtl/rmii_pkg.sv
// rmii_pkg: shared RMII framing types, line symbols and CRC-32 helpers
package rmii_pkg;
  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG} state_t;
  localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0] SFD_DIBIT = 2'b11;
  localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  function automatic logic [31:0] crc32_bit(logic [31:0] c, logic b);
    return (c >> 1) ^ ((c[0] ^ b) ? CRC32_POLY : 32'h0);
  endfunction
endpackage

// File: rtl/rmii_frame_tx_if.sv
// rmii_frame_tx_if: upstream frame/payload handshake into the RMII transmitter
interface rmii_frame_tx_if;
  logic trigger_in;
  logic [1:0] data_in;
  logic last_dibit_in;
  logic ready_out;
  logic data_ready_out;
  modport master(output trigger_in, data_in, last_dibit_in, input ready_out, data_ready_out);
  modport slave(input trigger_in, data_in, last_dibit_in, output ready_out, data_ready_out);
endinterface

// File: rtl/rmii_frame_tx_crc32_dibit.sv
// crc32_dibit: reflected CRC-32 accumulator consuming one dibit (bit0 first) per enabled cycle
module crc32_dibit
  import rmii_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        clr_in,
  input  logic        en_in,
  input  logic [1:0]  dibit_in,
  output logic [31:0] crc_out
);
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) crc_out <= CRC32_INIT;
    else if (clr_in) crc_out <= CRC32_INIT;
    else if (en_in) crc_out <= crc32_bit(crc32_bit(crc_out, dibit_in[0]), dibit_in[1]);
endmodule

// File: rtl/rmii_frame_tx.sv
// rmii_frame_tx: wraps upstream payload dibits in preamble/SFD, zero pad and CRC-32 FCS for an RMII PHY
module rmii_frame_tx
  import rmii_pkg::*;
#(
  parameter int PREAMBLE_DIBITS = 31,
  parameter int MIN_PAYLOAD_DIBITS = 240,
  parameter int IFG_DIBITS = 48
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  rmii_frame_tx_if.slave up,
  output logic           eth_txen,
  output logic [1:0]     eth_txd
);
  localparam logic [15:0] PRE_N = 16'(PREAMBLE_DIBITS);
  localparam logic [15:0] MIN_N = 16'(MIN_PAYLOAD_DIBITS);
  localparam logic [15:0] IFG_LAST = 16'(IFG_DIBITS - 1);
  state_t state;
  logic [15:0] cnt;
  logic [31:0] crc;
  logic more;
  assign up.ready_out = state == IDLE;
  assign more = cnt + 16'd1 < MIN_N;
  crc32_dibit u_crc (
    .clk_in,
    .rst_n_in,
    .clr_in(up.ready_out && up.trigger_in),
    .en_in(up.data_ready_out || state == PAD),
    .dibit_in(up.data_ready_out ? up.data_in : 2'b00),
    .crc_out(crc)
  );
  // cnt counts preamble dibits, then payload+pad dibits, then FCS dibits, then IFG cycles
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state <= IDLE;
      cnt <= '0;
      eth_txen <= 1'b0;
      eth_txd <= 2'b00;
      up.data_ready_out <= 1'b0;
    end else
      case (state)
        IDLE: if (up.trigger_in) begin
          state <= PREAMBLE;
          cnt <= 16'd1;
          eth_txen <= 1'b1;
          eth_txd <= PREAMBLE_DIBIT;
        end
        PREAMBLE: if (cnt == PRE_N) begin
          state <= SFD;
          cnt <= '0;
          eth_txd <= SFD_DIBIT;
          up.data_ready_out <= 1'b1;
        end else begin
          cnt <= cnt + 16'd1;
          eth_txd <= PREAMBLE_DIBIT;
        end
        SFD, DATA: begin
          eth_txd <= up.data_in;
          if (up.last_dibit_in) begin
            state <= more ? PAD : FCS;
            cnt <= more ? cnt + 16'd1 : '0;
            up.data_ready_out <= 1'b0;
          end else begin
            state <= DATA;
            cnt <= cnt < MIN_N ? cnt + 16'd1 : cnt;
          end
        end
        PAD: begin
          state <= more ? PAD : FCS;
          cnt <= more ? cnt + 16'd1 : '0;
          eth_txd <= 2'b00;
        end
        FCS: begin
          eth_txd <= ~crc[{cnt[3:0], 1'b0} +: 2];
          state <= cnt == 16'd15 ? IFG : FCS;
          cnt <= cnt == 16'd15 ? '0 : cnt + 16'd1;
        end
        IFG: begin
          eth_txen <= 1'b0;
          eth_txd <= 2'b00;
          state <= cnt == IFG_LAST ? IDLE : IFG;
          cnt <= cnt == IFG_LAST ? '0 : cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
endmodule
